// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad pulse generator: key width, FSM encoding,
// default timing values and a saturating increment helper.
package keypad_pkg;

  localparam int KEY_W            = 4;
  localparam int DEBOUNCE_DEFAULT = 4;
  localparam int REPEAT_DEFAULT   = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer bringing the raw push-button vector into the clk domain.
module key_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Debounced one-hot key pulse generator with a held indicator.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module key_pulse_gen
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_CYCLES = REPEAT_DEFAULT
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] buttons,
  output logic [KEY_W-1:0] keys,
  output logic             held
);

  localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_CYCLES);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [7:0] RPT_LIM = 8'(REPEAT_CYCLES);
`endif

  logic [KEY_W-1:0] sb;
  state_e           state_q, state_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0] keys_q, keys_d;
  logic             held_q, held_d;
`ifdef KEYPAD_REPEAT_EN
  logic [7:0]       rpt_q, rpt_d;
`endif

  key_sync #(.WIDTH(KEY_W)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (buttons),
    .sync_o  (sb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      keys_q  <= '0;
      held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      keys_q  <= keys_d;
      held_q  <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  // keys_d defaults to zero so every pulse lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    keys_d  = '0;
    held_d  = held_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    case (state_q)
      IDLE: begin
        if ($onehot(sb)) begin
          cand_d  = sb;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sb != cand_q) begin
          state_d = IDLE;
        end else begin
          cnt_d = satInc(cnt_q);
          if (satInc(cnt_q) == DEB_LIM) begin
            keys_d  = cand_q;
            held_d  = 1'b1;
            state_d = HOLD;
`ifdef KEYPAD_REPEAT_EN
            rpt_d   = '0;
`endif
          end
        end
      end
      HOLD: begin
        // Extra keys or swaps while held are deliberately ignored.
        if (sb == '0) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (sb == cand_q) begin
          rpt_d = satInc(rpt_q);
          if (satInc(rpt_q) == RPT_LIM) begin
            keys_d = cand_q;
            rpt_d  = '0;
          end
        end
`endif
      end
      RELEASE: begin
        if (sb != '0) begin
          state_d = HOLD;
`ifdef KEYPAD_REPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          cnt_d = satInc(cnt_q);
          if (satInc(cnt_q) == DEB_LIM) begin
            held_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign keys = keys_q;
  assign held = held_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen; expected pulses are queued with their edge
// number and matched by a monitor. Define KEYPAD_REPEAT_EN to cover auto-repeat.
module tb_key_pulse_gen;

  typedef struct {
    int         edgeNum;
    logic [3:0] key;
  } expect_t;

  logic       clk;
  logic       reset;
  logic [3:0] buttons;
  logic [3:0] keys;
  logic       held;

  int      edgeCnt  = 0;
  int      errors   = 0;
  int      checks   = 0;
  expect_t sbQ[$];

`ifdef KEYPAD_REPEAT_EN
  key_pulse_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .buttons(buttons), .keys(keys), .held(held));
`else
  key_pulse_gen #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .buttons(buttons), .keys(keys), .held(held));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt++;

  // Every nonzero keys sample must match the oldest queued expectation.
  always @(negedge clk) begin
    if (keys !== 4'b0000) begin
      checks++;
      assert (sbQ.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpectedPulse edge=%0d keys=%b required none", edgeCnt, keys);
      end
      if (sbQ.size() != 0) begin
        expect_t e;
        e = sbQ.pop_front();
        assert (e.edgeNum == edgeCnt && e.key === keys) else begin
          errors++;
          $error("[TB] FAIL pulse observed edge=%0d keys=%b required edge=%0d keys=%b",
                 edgeCnt, keys, e.edgeNum, e.key);
        end
      end
    end
  end

  // Advance to the falling edge after rising edge k.
  task automatic gotoEdge(input int k);
    while (edgeCnt < k) @(negedge clk);
  endtask

  task automatic applyStimulus(input int k, input logic [3:0] b);
    gotoEdge(k);
    buttons = b;
  endtask

  task automatic expectPulse(input int k, input logic [3:0] key);
    expect_t e;
    e.edgeNum = k;
    e.key     = key;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] obsV, input logic [3:0] expV);
    checks++;
    assert (obsV === expV) else begin
      errors++;
      $error("[TB] FAIL %s edge=%0d observed=%b expected=%b", tag, edgeCnt, obsV, expV);
    end
  endtask

  initial begin
    reset   = 1'b0;
    buttons = 4'b0000;

    gotoEdge(1);
    checkOutput("resetKeys", keys, 4'b0000);
    checkOutput("resetHeld", {3'b0, held}, 4'b0000);
    gotoEdge(2);
    reset = 1'b1;

    // Single press, stable from before edge 10.
    applyStimulus(9, 4'b0001);
    expectPulse(16, 4'b0001);
    gotoEdge(15); checkOutput("heldBeforePulse", {3'b0, held}, 4'b0000);
    gotoEdge(16); checkOutput("heldAtPulse", {3'b0, held}, 4'b0001);
    applyStimulus(29, 4'b0000);
    gotoEdge(35); checkOutput("heldDuringRelease", {3'b0, held}, 4'b0001);
    gotoEdge(36); checkOutput("heldAfterRelease", {3'b0, held}, 4'b0000);

    // Bouncing key never settles long enough.
    for (int i = 0; i < 6; i++)
      applyStimulus(40 + 2 * i, (i % 2 == 0) ? 4'b0100 : 4'b0000);
    applyStimulus(52, 4'b0000);
    for (int k = 41; k <= 58; k += 4) begin
      gotoEdge(k); checkOutput("bounceHeld", {3'b0, held}, 4'b0000);
    end

    // Multi-hot is rejected, then a clean single key is accepted.
    applyStimulus(59, 4'b1010);
    gotoEdge(75); checkOutput("multiHotHeld", {3'b0, held}, 4'b0000);
    applyStimulus(79, 4'b0010);
    expectPulse(86, 4'b0010);
    applyStimulus(99, 4'b0000);
    gotoEdge(108); checkOutput("afterMultiHeld", {3'b0, held}, 4'b0000);

    // Four keys in sequence with gaps.
    applyStimulus(109, 4'b0001); expectPulse(116, 4'b0001);
    applyStimulus(119, 4'b0000);
    applyStimulus(129, 4'b0100); expectPulse(136, 4'b0100);
    applyStimulus(139, 4'b0000);
    applyStimulus(149, 4'b1000); expectPulse(156, 4'b1000);
    applyStimulus(159, 4'b0000);
    applyStimulus(169, 4'b0010); expectPulse(176, 4'b0010);
    applyStimulus(179, 4'b0000);

    // Extra key while held produces no pulse.
    applyStimulus(189, 4'b0001); expectPulse(196, 4'b0001);
    applyStimulus(197, 4'b0011);
    gotoEdge(202); checkOutput("extraKeyHeld", {3'b0, held}, 4'b0001);
    applyStimulus(203, 4'b0000);

    // Reset mid-press: no pulse at 226, full debounce after reset release.
    applyStimulus(219, 4'b0001);
    gotoEdge(223); reset = 1'b0;
    gotoEdge(224);
    checkOutput("midResetKeys", keys, 4'b0000);
    checkOutput("midResetHeld", {3'b0, held}, 4'b0000);
    gotoEdge(226); reset = 1'b1;
    expectPulse(233, 4'b0001);
    gotoEdge(232); checkOutput("postResetHeld", {3'b0, held}, 4'b0000);
    applyStimulus(244, 4'b0000);

    // Long hold: repeats only when the feature is built in.
    applyStimulus(259, 4'b1000);
    expectPulse(266, 4'b1000);
`ifdef KEYPAD_REPEAT_EN
    expectPulse(282, 4'b1000);
    expectPulse(298, 4'b1000);
    expectPulse(314, 4'b1000);
`endif
    applyStimulus(319, 4'b0000);
    gotoEdge(325); checkOutput("longHoldHeld", {3'b0, held}, 4'b0001);
    gotoEdge(326); checkOutput("longHoldReleased", {3'b0, held}, 4'b0000);

    gotoEdge(340);
    checks++;
    assert (sbQ.size() == 0) else begin
      errors++;
      $error("[TB] FAIL missingPulses observed=%0d pending required=0 (next edge=%0d)",
             sbQ.size(), sbQ[0].edgeNum);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
